// File: rtl/serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx
//
// Receive-side serial-to-parallel converter and byte aligner. It consumes a
// 1-bit MSB-first serial stream clocked by clk_32f. It hunts for the idle comma
// byte and locks byte alignment after LOCK_COUNT consecutive boundary-aligned
// commas. Once locked, it presents each received byte for 8 clk_32f cycles.
//
// Parameters:
//   COMMA      idle / alignment byte (nonzero)
//   LOCK_COUNT consecutive aligned commas needed to declare sync (1..15)
//
// Ports:
//   clk_32f    serial bit clock, the only clock
//   reset      asynchronous active-low reset
//   data_in    serial bit, one per clk_32f cycle, MSB of each byte first
//   data_out   last byte received at a boundary while in sync
//   valid_out  data_out holds a non-comma byte (level, held 8 cycles)
//   active     byte alignment locked (sticky until reset)
// -----------------------------------------------------------------------------
module serial_paralelo_rx #(
   parameter logic [7:0]  COMMA      = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      ALIGN = 2'd1,
      SYNC  = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

   state_t     state;
   logic [7:0] sr;
   logic [2:0] bit_cnt;
   logic [3:0] comma_cnt;

   // The 8 bits ending with the bit sampled at the current edge.
   logic [7:0] word;
   logic       is_comma;
   logic       boundary;

   assign word     = {sr[6:0], data_in};
   assign is_comma = (word == COMMA);
   assign boundary = (bit_cnt == 3'd7);

   // NOTE: every register here, state and outputs alike, is assigned with <=
   // so all reads in this block see pre-edge values; blocking assignments
   // would let a later statement observe an updated bit_cnt or comma_cnt.
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         // NOTE: everything, including the shift register, is cleared so a
         // reset mid-byte cannot leave stale bits that fake a comma later.
         state     <= HUNT;
         sr        <= 8'h00;
         bit_cnt   <= 3'd0;
         comma_cnt <= 4'd0;
         data_out  <= 8'h00;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         sr      <= word;
         bit_cnt <= bit_cnt + 3'd1;

         case (state)
            HUNT: begin
               // Bit alignment is unknown here, so look at every edge. A hit
               // restarts bit_cnt so the next boundary lands 8 edges later.
               if (is_comma) begin
                  bit_cnt   <= 3'd0;
                  comma_cnt <= 4'd1;
                  if (LOCK_N == 4'd1) begin
                     state  <= SYNC;
                     active <= 1'b1;
                  end else begin
                     state <= ALIGN;
                  end
               end else begin
                  comma_cnt <= 4'd0;
               end
            end

            ALIGN: begin
               // Confirm alignment only on boundaries; a false comma that
               // straddled two bytes fails at the first non-comma boundary.
               if (boundary) begin
                  if (is_comma) begin
                     comma_cnt <= comma_cnt + 4'd1;
                     if (comma_cnt + 4'd1 == LOCK_N) begin
                        state  <= SYNC;
                        active <= 1'b1;
                     end
                  end else begin
                     state     <= HUNT;
                     comma_cnt <= 4'd0;
                  end
               end
            end

            SYNC: begin
               // Sticky; outputs update once per byte and hold in between.
               if (boundary) begin
                  data_out  <= word;
                  valid_out <= !is_comma;
               end
            end

            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_rx
//
// Bench for serial_paralelo_rx. dut_a uses LOCK_COUNT = 4 and dut_b uses
// LOCK_COUNT = 1. Stimulus processes push expected {data, valid, active}
// triples, each tagged with the cycle it applies to, into a queue. A monitor
// samples the DUTs on the falling edge and pops and compares every entry that
// is due.
//
// Cycle bookkeeping: cyc counts rising edges. A test records base = cyc at
// the falling edge where it drives bit 0. Bit k is therefore sampled on rising
// edge base+k, and "after edge k" means the falling edge where cyc == base+k+1.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_rx;

   logic       clk_32f;
   logic       reset;
   logic       din_a, din_b;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic       active_a, active_b;

   serial_paralelo_rx #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut_a (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .data_in   (din_a),
      .data_out  (data_a),
      .valid_out (valid_a),
      .active    (active_a)
   );

   serial_paralelo_rx #(.COMMA(8'hBC), .LOCK_COUNT(1)) dut_b (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .data_in   (din_b),
      .data_out  (data_b),
      .valid_out (valid_b),
      .active    (active_b)
   );

   initial clk_32f = 1'b0;
   always #5 clk_32f = ~clk_32f;

   int cyc = 0;
   always @(posedge clk_32f) cyc <= cyc + 1;

   typedef struct {
      int         at;
      int         dut;
      logic [7:0] data;
      logic       valid;
      logic       active;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   base;

   // got/exp packed as {active, valid, data}
   task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got active=%b valid=%b data=%h, expected active=%b valid=%b data=%h",
                  name, cyc, got[9], got[8], got[7:0], exp[9], exp[8], exp[7:0]);
      end
   endtask

   task automatic expect_at(input int at, input int dut, input logic [7:0] d,
                            input logic v, input logic a, input string name);
      exp_t e;
      e.at = at; e.dut = dut; e.data = d; e.valid = v; e.active = a; e.name = name;
      sb.push_back(e);
   endtask

   task automatic expect_span(input int from, input int to, input int dut, input logic [7:0] d,
                              input logic v, input logic a, input string name);
      for (int k = from; k <= to; k++) expect_at(base + k, dut, d, v, a, name);
   endtask

   // Monitor: compare every scoreboard entry that is due at this falling edge.
   exp_t mon_e;
   always @(negedge clk_32f) begin
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.at < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cyc %0d was never sampled (now %0d)",
                     mon_e.name, mon_e.at, cyc);
         end else if (mon_e.dut == 0) begin
            check(mon_e.name, {active_a, valid_a, data_a}, {mon_e.active, mon_e.valid, mon_e.data});
         end else begin
            check(mon_e.name, {active_b, valid_b, data_b}, {mon_e.active, mon_e.valid, mon_e.data});
         end
      end
   end

   // Drive one bit at the current falling edge and hold it until the next.
   task automatic send_bit(input int dut, input logic b);
      if (dut == 0) din_a = b;
      else          din_b = b;
      @(negedge clk_32f);
   endtask

   task automatic send_byte(input int dut, input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(dut, v[i]);
   endtask

   // Keep clocking zeros until the monitor has consumed every pending entry.
   task automatic drain(input string name);
      din_a = 1'b0;
      din_b = 1'b0;
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk_32f);
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: %0d expectations still pending after timeout", name, sb.size());
         sb.delete();
      end
   endtask

   // Starts and ends on a falling edge, so the caller can take base = cyc.
   task automatic do_reset();
      reset = 1'b0;
      din_a = 1'b0;
      din_b = 1'b0;
      repeat (2) @(negedge clk_32f);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      din_a = 1'b0;
      din_b = 1'b0;
      repeat (2) @(negedge clk_32f);
      check("reset_state_a", {active_a, valid_a, data_a}, 10'h000);
      check("reset_state_b", {active_b, valid_b, data_b}, 10'h000);
      reset = 1'b1;

      // Test 1: aligned lock, 4x BC then A5.
      base = cyc;
      expect_at(base + 31, 0, 8'h00, 1'b0, 1'b0, "t1_prelock");
      expect_at(base + 32, 0, 8'h00, 1'b0, 1'b1, "t1_lock");
      expect_at(base + 39, 0, 8'h00, 1'b0, 1'b1, "t1_before_data");
      expect_span(40, 47, 0, 8'hA5, 1'b1, 1'b1, "t1_data_hold");
      repeat (4) send_byte(0, 8'hBC);
      send_byte(0, 8'hA5);
      drain("t1_drain");

      // Test 2: misaligned lock, junk bits 1,0,1 then 4x BC then 3C.
      do_reset();
      base = cyc;
      expect_at(base + 34, 0, 8'h00, 1'b0, 1'b0, "t2_prelock");
      expect_at(base + 35, 0, 8'h00, 1'b0, 1'b1, "t2_lock");
      expect_at(base + 42, 0, 8'h00, 1'b0, 1'b1, "t2_before_data");
      expect_at(base + 43, 0, 8'h3C, 1'b1, 1'b1, "t2_data");
      send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1);
      repeat (4) send_byte(0, 8'hBC);
      send_byte(0, 8'h3C);
      drain("t2_drain");

      // Test 3: lock failure, 3x BC, 55 (back to HUNT), 4x BC, 12.
      do_reset();
      base = cyc;
      expect_at(base + 24, 0, 8'h00, 1'b0, 1'b0, "t3_three_commas");
      expect_at(base + 32, 0, 8'h00, 1'b0, 1'b0, "t3_rejected");
      expect_at(base + 63, 0, 8'h00, 1'b0, 1'b0, "t3_prelock");
      expect_at(base + 64, 0, 8'h00, 1'b0, 1'b1, "t3_lock");
      expect_at(base + 71, 0, 8'h00, 1'b0, 1'b1, "t3_before_data");
      expect_at(base + 72, 0, 8'h12, 1'b1, 1'b1, "t3_data");
      repeat (3) send_byte(0, 8'hBC);
      send_byte(0, 8'h55);
      repeat (4) send_byte(0, 8'hBC);
      send_byte(0, 8'h12);
      drain("t3_drain");

      // Test 4: idle comma inserted between data bytes while in sync.
      do_reset();
      base = cyc;
      expect_span(40, 47, 0, 8'h11, 1'b1, 1'b1, "t4_byte0");
      expect_span(48, 55, 0, 8'hBC, 1'b0, 1'b1, "t4_idle");
      expect_span(56, 63, 0, 8'h22, 1'b1, 1'b1, "t4_byte2");
      repeat (4) send_byte(0, 8'hBC);
      send_byte(0, 8'h11);
      send_byte(0, 8'hBC);
      send_byte(0, 8'h22);
      drain("t4_drain");

      // Test 5: asynchronous reset mid-byte while in sync, then a fresh re-lock.
      do_reset();
      base = cyc;
      expect_at(base + 40, 0, 8'hA5, 1'b1, 1'b1, "t5_synced");
      repeat (4) send_byte(0, 8'hBC);
      send_byte(0, 8'hA5);
      send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1);
      @(posedge clk_32f);
      #2 reset = 1'b0;
      #1 check("t5_async_reset", {active_a, valid_a, data_a}, 10'h000);
      @(negedge clk_32f);
      reset = 1'b1;
      din_a = 1'b0;
      base = cyc;
      // 66, 3x BC, 77 (aborts), 4x BC, 99: nothing valid until the 4th new BC.
      expect_span(1, 71, 0, 8'h00, 1'b0, 1'b0, "t5_no_valid");
      expect_at(base + 72, 0, 8'h00, 1'b0, 1'b1, "t5_relock");
      expect_at(base + 80, 0, 8'h99, 1'b1, 1'b1, "t5_data");
      send_byte(0, 8'h66);
      repeat (3) send_byte(0, 8'hBC);
      send_byte(0, 8'h77);
      repeat (4) send_byte(0, 8'hBC);
      send_byte(0, 8'h99);
      drain("t5_drain");

      // Test 6: LOCK_COUNT = 1 variant on dut_b, BC then 7E.
      do_reset();
      base = cyc;
      expect_at(base + 7,  1, 8'h00, 1'b0, 1'b0, "t6_prelock");
      expect_at(base + 8,  1, 8'h00, 1'b0, 1'b1, "t6_lock");
      expect_at(base + 15, 1, 8'h00, 1'b0, 1'b1, "t6_before_data");
      expect_at(base + 16, 1, 8'h7E, 1'b1, 1'b1, "t6_data");
      send_byte(1, 8'hBC);
      send_byte(1, 8'h7E);
      drain("t6_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
